// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file write scheduler.
// Holds the FSM and grant encodings, the datapath sizes and small
// address helpers used by both the scheduler and its arbiter.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 8;
   localparam int IDX_W    = $clog2(NUM_REGS);

   // Scheduler FSM encoding
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Grant encoding, also used for the remembered last grant
   localparam logic [0:0] GNT_ALU = 1'b0;
   localparam logic [0:0] GNT_MEM = 1'b1;

   // True when the address names an implemented register
   function automatic logic regInRange(input logic [ADDR_W-1:0] r);
      return (r < ADDR_W'(NUM_REGS));
   endfunction

   // One-hot decode of a register address; out-of-range decodes to zero
   function automatic logic [NUM_REGS-1:0] regDecode(input logic [ADDR_W-1:0] r);
      logic [NUM_REGS-1:0] d;
      d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r == ADDR_W'(i)) d[i] = 1'b1;
      end
      return d;
   endfunction

endpackage

// File: rtl/regfile_write_sched_rr_arb2.sv
// Two-way round-robin arbiter for the register-file write port.
// req[0] is the ALU, req[1] the memory stage. When both request, the
// one that did not win last time is granted. next_last reports the
// grant to remember (unchanged when nothing is granted).
module rr_arb2
   import regfile_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt,
   output logic       next_last
);

   // Pick at most one requester, alternating on contention
   always_comb begin
      gnt       = 2'b00;
      next_last = last_grant;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant == GNT_MEM) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
      if (gnt[0])      next_last = GNT_ALU;
      else if (gnt[1]) next_last = GNT_MEM;
   end

endmodule

// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler.
// After reset an init sweep writes every register with its own index,
// then ALU and load write-backs are round-robin arbitrated onto the
// single write port. A pending-write scoreboard (busy_mask) tracks
// reserved destinations for hazard detection in decode.
// Optional feature macro: REGFILE_ZERO_PROTECT_EN (reg 0 becomes
// read-only in RUN and is never marked busy).
//
// Handshake: each requester holds valid with stable reg/data until it
// sees ready; a transfer happens on any posedge where valid && ready.
// ready is a combinational grant and never depends on anything but the
// valids, the FSM state and the last grant.
module regfile_write_sched
   import regfile_pkg::*;
(
   input  logic                clock_in,
   input  logic                reset,
   input  logic                alu_valid,
   output logic                alu_ready,
   input  logic [ADDR_W-1:0]   alu_reg,
   input  logic [DATA_W-1:0]   alu_data,
   input  logic                mem_valid,
   output logic                mem_ready,
   input  logic [ADDR_W-1:0]   mem_reg,
   input  logic [DATA_W-1:0]   mem_data,
   input  logic                rsv_valid,
   input  logic [ADDR_W-1:0]   rsv_reg,
   output logic                regWrite,
   output logic [ADDR_W-1:0]   writeReg,
   output logic [DATA_W-1:0]   writeData,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                init_done,
   output logic                err_oob,
   output logic                dbgState
);

   logic [0:0]          state;
   logic [IDX_W-1:0]    initCnt;
   logic                lastGrant;

   logic [1:0]          arbReq;
   logic [1:0]          gnt;
   logic                nextLast;

   logic                accept;
   logic [ADDR_W-1:0]   selReg;
   logic [DATA_W-1:0]   selData;
   logic                selInRange;
   logic                dropZero;
   logic                rsvAllowed;
   logic                writeOk;
   logic [NUM_REGS-1:0] clrMask;
   logic [NUM_REGS-1:0] setMask;
   logic [NUM_REGS-1:0] busyNext;

   // Requests are only visible to the arbiter once the sweep is over
   always_comb begin
      arbReq = 2'b00;
      if (state == ST_RUN) arbReq = {mem_valid, alu_valid};
   end

   rr_arb2 u_arb (
      .req        (arbReq),
      .last_grant (lastGrant),
      .gnt        (gnt),
      .next_last  (nextLast)
   );

   assign alu_ready = gnt[0];
   assign mem_ready = gnt[1];
   assign dbgState  = state;

   // Select the granted request and classify its destination
   always_comb begin
      accept     = |gnt;
      selReg     = gnt[1] ? mem_reg  : alu_reg;
      selData    = gnt[1] ? mem_data : alu_data;
      selInRange = regInRange(selReg);
`ifdef REGFILE_ZERO_PROTECT_EN
      dropZero   = (selReg == '0);
      rsvAllowed = regInRange(rsv_reg) && (rsv_reg != '0);
`else
      dropZero   = 1'b0;
      rsvAllowed = regInRange(rsv_reg);
`endif
      writeOk    = accept && selInRange && !dropZero;
   end

   // Next scoreboard value: completed writes clear, reservations set (set wins)
   always_comb begin
      clrMask  = '0;
      setMask  = '0;
      if (accept && selInRange) clrMask = regDecode(selReg);
      if (rsv_valid && rsvAllowed) setMask = regDecode(rsv_reg);
      busyNext = (busy_mask & ~clrMask) | setMask;
   end

   // Scoreboard and arbitration history
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         busy_mask <= '0;
         lastGrant <= GNT_MEM;
      end else begin
         busy_mask <= busyNext;
         lastGrant <= nextLast;
      end
   end

   // FSM, init sweep and registered write-port outputs
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         state     <= ST_INIT;
         initCnt   <= '0;
         regWrite  <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
         init_done <= 1'b0;
         err_oob   <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               regWrite  <= 1'b1;
               writeReg  <= ADDR_W'(initCnt);
               writeData <= DATA_W'(initCnt);
               err_oob   <= 1'b0;
               initCnt   <= initCnt + IDX_W'(1);
               if (initCnt == IDX_W'(NUM_REGS - 1)) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            default: begin
               regWrite <= writeOk;
               err_oob  <= accept && !selInRange;
               if (writeOk) begin
                  writeReg  <= selReg;
                  writeData <= selData;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched: init sweep, single writes,
// round-robin contention, scoreboard set/clear, out-of-range requests,
// reg 0 handling for either build, and mid-run reset.
module tb_regfile_write_sched;
   import regfile_pkg::*;

   logic                clock_in;
   logic                reset;
   logic                alu_valid;
   logic                alu_ready;
   logic [ADDR_W-1:0]   alu_reg;
   logic [DATA_W-1:0]   alu_data;
   logic                mem_valid;
   logic                mem_ready;
   logic [ADDR_W-1:0]   mem_reg;
   logic [DATA_W-1:0]   mem_data;
   logic                rsv_valid;
   logic [ADDR_W-1:0]   rsv_reg;
   logic                regWrite;
   logic [ADDR_W-1:0]   writeReg;
   logic [DATA_W-1:0]   writeData;
   logic [NUM_REGS-1:0] busy_mask;
   logic                init_done;
   logic                err_oob;
   logic                dbgState;

   int total = 0;
   int bad   = 0;

   regfile_write_sched dut (
      .clock_in  (clock_in),
      .reset     (reset),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_reg   (alu_reg),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_reg   (mem_reg),
      .mem_data  (mem_data),
      .rsv_valid (rsv_valid),
      .rsv_reg   (rsv_reg),
      .regWrite  (regWrite),
      .writeReg  (writeReg),
      .writeData (writeData),
      .busy_mask (busy_mask),
      .init_done (init_done),
      .err_oob   (err_oob),
      .dbgState  (dbgState)
   );

   // Clock
   initial begin
      clock_in = 1'b0;
      forever #5 clock_in = ~clock_in;
   end

   // Advance to just after the next active edge
   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset     = 1'b0;
      alu_valid = 1'b1;
      alu_reg   = 5'd1;
      alu_data  = 32'h1111_1111;
      mem_valid = 1'b1;
      mem_reg   = 5'd2;
      mem_data  = 32'h2222_2222;
      rsv_valid = 1'b0;
      rsv_reg   = '0;

      // 1. Reset values, then the init sweep
      repeat (3) tick();
      chk("rst_regWrite",  regWrite,  0);
      chk("rst_writeReg",  writeReg,  0);
      chk("rst_writeData", writeData, 0);
      chk("rst_busy",      busy_mask, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_err_oob",   err_oob,   0);
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_state",     dbgState,  0);
      reset = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
         #1;
         chk($sformatf("init%0d_alu_ready", i), alu_ready, 0);
         chk($sformatf("init%0d_mem_ready", i), mem_ready, 0);
         tick();
         chk($sformatf("init%0d_regWrite", i),  regWrite,  1);
         chk($sformatf("init%0d_writeReg", i),  writeReg,  i);
         chk($sformatf("init%0d_writeData", i), writeData, i);
         chk($sformatf("init%0d_done", i),      init_done, (i == NUM_REGS - 1) ? 1 : 0);
         if (i == 2) begin
            rsv_valid = 1'b1;
            rsv_reg   = 5'd2;
         end
         if (i == 3) begin
            rsv_valid = 1'b0;
            chk("init_rsv_busy", busy_mask, 64'h04);
         end
      end
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      #1;
      chk("run_state", dbgState, 1);
      chk("run_idle_alu_ready", alu_ready, 0);

      // 2. Single ALU write to reg 3
      alu_valid = 1'b1;
      alu_reg   = 5'd3;
      alu_data  = 32'hDEAD_BEEF;
      #1;
      chk("t2_alu_ready", alu_ready, 1);
      chk("t2_mem_ready", mem_ready, 0);
      tick();
      alu_valid = 1'b0;
      chk("t2_regWrite",  regWrite,  1);
      chk("t2_writeReg",  writeReg,  3);
      chk("t2_writeData", writeData, 32'hDEAD_BEEF);
      tick();
      chk("t2_idle_regWrite",  regWrite,  0);
      chk("t2_hold_writeReg",  writeReg,  3);
      chk("t2_hold_writeData", writeData, 32'hDEAD_BEEF);

      // Lone MEM write to reg 2 clears its reservation; last grant becomes MEM
      mem_valid = 1'b1;
      mem_reg   = 5'd2;
      mem_data  = 32'h1234_5678;
      #1;
      chk("m2_mem_ready", mem_ready, 1);
      chk("m2_alu_ready", alu_ready, 0);
      tick();
      mem_valid = 1'b0;
      chk("m2_writeReg",  writeReg,  2);
      chk("m2_writeData", writeData, 32'h1234_5678);
      chk("m2_busy",      busy_mask, 0);

      // 3. Contention for 4 cycles: ALU, MEM, ALU, MEM
      alu_valid = 1'b1;
      mem_valid = 1'b1;
      alu_reg   = 5'd1;
      mem_reg   = 5'd4;
      for (int k = 0; k < 4; k++) begin
         alu_data = 32'hA0 + k;
         mem_data = 32'hB0 + k;
         #1;
         chk($sformatf("rr%0d_alu_ready", k), alu_ready, (k % 2 == 0) ? 1 : 0);
         chk($sformatf("rr%0d_mem_ready", k), mem_ready, (k % 2 == 1) ? 1 : 0);
         tick();
         chk($sformatf("rr%0d_regWrite", k),  regWrite,  1);
         chk($sformatf("rr%0d_writeReg", k),  writeReg,  (k % 2 == 0) ? 1 : 4);
         chk($sformatf("rr%0d_writeData", k), writeData, (k % 2 == 0) ? (32'hA0 + k) : (32'hB0 + k));
      end
      alu_valid = 1'b0;
      mem_valid = 1'b0;

      // 4. Scoreboard: reserve 5, write+reserve 5 (set wins), plain write clears
      rsv_valid = 1'b1;
      rsv_reg   = 5'd5;
      tick();
      chk("t4_rsv_busy",     busy_mask, 64'h20);
      chk("t4_rsv_regWrite", regWrite,  0);
      mem_valid = 1'b1;
      mem_reg   = 5'd5;
      mem_data  = 32'h55;
      tick();
      chk("t4_setwins_busy", busy_mask, 64'h20);
      chk("t4_setwins_reg",  writeReg,  5);
      rsv_valid = 1'b0;
      mem_data  = 32'h66;
      tick();
      mem_valid = 1'b0;
      chk("t4_clear_busy", busy_mask, 0);
      chk("t4_clear_data", writeData, 32'h66);

      // 5. Out-of-range ALU write and out-of-range reservation
      alu_valid = 1'b1;
      alu_reg   = 5'd12;
      alu_data  = 32'hCC;
      rsv_valid = 1'b1;
      rsv_reg   = 5'd9;
      #1;
      chk("t5_alu_ready", alu_ready, 1);
      tick();
      alu_valid = 1'b0;
      rsv_valid = 1'b0;
      chk("t5_err_oob",   err_oob,   1);
      chk("t5_regWrite",  regWrite,  0);
      chk("t5_writeReg",  writeReg,  5);
      chk("t5_writeData", writeData, 32'h66);
      chk("t5_busy",      busy_mask, 0);
      tick();
      chk("t5_err_clear", err_oob, 0);

      // Reg 0 write with a same-cycle reservation of reg 0
      alu_valid = 1'b1;
      alu_reg   = 5'd0;
      alu_data  = 32'h77;
      rsv_valid = 1'b1;
      rsv_reg   = 5'd0;
      #1;
      chk("z_alu_ready", alu_ready, 1);
      tick();
      alu_valid = 1'b0;
      rsv_valid = 1'b0;
      chk("z_err_oob", err_oob, 0);
`ifdef REGFILE_ZERO_PROTECT_EN
      chk("z_regWrite",  regWrite,  0);
      chk("z_writeData", writeData, 32'h66);
      chk("z_busy",      busy_mask, 0);
`else
      chk("z_regWrite",  regWrite,  1);
      chk("z_writeReg",  writeReg,  0);
      chk("z_writeData", writeData, 32'h77);
      chk("z_busy",      busy_mask, 64'h01);
`endif

      // 6. Reset mid-run with both requesters valid
      alu_valid = 1'b1;
      alu_reg   = 5'd1;
      alu_data  = 32'hF1;
      mem_valid = 1'b1;
      mem_reg   = 5'd2;
      mem_data  = 32'hF2;
      tick();
      chk("t6_inflight", regWrite, 1);
      reset = 1'b0;
      #1;
      chk("t6_regWrite",  regWrite,  0);
      chk("t6_writeReg",  writeReg,  0);
      chk("t6_writeData", writeData, 0);
      chk("t6_busy",      busy_mask, 0);
      chk("t6_init_done", init_done, 0);
      chk("t6_err_oob",   err_oob,   0);
      chk("t6_alu_ready", alu_ready, 0);
      chk("t6_mem_ready", mem_ready, 0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk($sformatf("t6_re%0d_alu_ready", i), alu_ready, 0);
         tick();
         chk($sformatf("t6_re%0d_regWrite", i), regWrite, 1);
         chk($sformatf("t6_re%0d_writeReg", i), writeReg, i);
         chk($sformatf("t6_re%0d_writeData", i), writeData, i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
